// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with modulo limit, programmable step, parallel
// load, wrap or saturate behaviour, and overflow/underflow pulse and sticky flags.
module updown_counter_param #(
   parameter int WIDTH     = 4,
   parameter int MAX_VAL   = 2**WIDTH - 1,
   parameter int STEP_W    = WIDTH,
   parameter bit SATURATE  = 1'b0,
   parameter int RESET_VAL = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              increment,
   input  logic              decrement,
   input  logic [STEP_W-1:0] step,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_val,
   input  logic              clr_sticky,
   output logic [WIDTH-1:0]  count,
   output logic              ovf_pulse,
   output logic              unf_pulse,
   output logic              ovf_sticky,
   output logic              unf_sticky,
   output logic              at_max,
   output logic              at_min
);

   // Step may be wider than the count, so the clamp compare runs at the wider of the two.
   localparam int CW = (STEP_W > WIDTH) ? STEP_W : WIDTH;
   localparam logic [CW-1:0]    MAX_CW  = CW'(MAX_VAL);
   localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
   localparam logic [WIDTH:0]   MODULUS = (WIDTH+1)'(MAX_VAL + 1);
   localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VAL);

   logic [CW-1:0]    step_ext;
   logic [WIDTH:0]   eff_step;
   logic [WIDTH:0]   count_ext;
   logic [WIDTH:0]   up_sum;
   logic [WIDTH:0]   down_wrap;
   logic [WIDTH-1:0] next_count;
   logic             ovf_event;
   logic             unf_event;

   assign step_ext  = CW'(step);
   assign eff_step  = (step_ext > MAX_CW) ? MAX_EXT : (WIDTH+1)'(step_ext);
   assign count_ext = {1'b0, count};
   assign up_sum    = count_ext + eff_step;
   assign down_wrap = count_ext + MODULUS - eff_step;

   // Load beats counting; opposing requests cancel out and leave the count alone.
   always_comb begin
      next_count = count;
      ovf_event  = 1'b0;
      unf_event  = 1'b0;
      if (load) begin
         next_count = (load_val > MAX_W) ? MAX_W : load_val;
      end else if (increment && !decrement) begin
         if (up_sum <= MAX_EXT) begin
            next_count = WIDTH'(up_sum);
         end else begin
            ovf_event  = 1'b1;
            next_count = SATURATE ? MAX_W : WIDTH'(up_sum - MODULUS);
         end
      end else if (decrement && !increment) begin
         if (eff_step <= count_ext) begin
            next_count = WIDTH'(count_ext - eff_step);
         end else begin
            unf_event  = 1'b1;
            next_count = SATURATE ? '0 : WIDTH'(down_wrap);
         end
      end
   end

   // A fresh event beats a simultaneous sticky clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         count      <= RESET_W;
         ovf_pulse  <= 1'b0;
         unf_pulse  <= 1'b0;
         ovf_sticky <= 1'b0;
         unf_sticky <= 1'b0;
      end else begin
         count      <= next_count;
         ovf_pulse  <= ovf_event;
         unf_pulse  <= unf_event;
         ovf_sticky <= (ovf_sticky & ~clr_sticky) | ovf_event;
         unf_sticky <= (unf_sticky & ~clr_sticky) | unf_event;
      end
   end

   assign at_max = (count == MAX_W);
   assign at_min = (count == '0);

endmodule
